turn_scheduler: RTL

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/turn_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/turn_scheduler.sv
// Turn scheduler for a two-player cat/dog throwing game.
// Gates the space key to the active player's power bar, samples the charged
// force after a settle delay, launches the projectile, applies hits and
// alternates turns until one player runs out of hit points.
module turn_scheduler #(
    parameter int unsigned HP_INIT        = 5,
    parameter int unsigned MIN_FORCE      = 1,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned FLIGHT_TIMEOUT = 390_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       space_in,
    input  logic [9:0] force_cat,
    input  logic [9:0] force_dog,
    input  logic       throw_done,
    input  logic       hit,
    output logic       space_cat,
    output logic       space_dog,
    output logic       turn_dog,
    output logic       throw_start,
    output logic [9:0] throw_force_out,
    output logic [2:0] hp_cat,
    output logic [2:0] hp_dog,
    output logic       game_over,
    output logic       winner_dog
);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_WAIT,
        ST_CHARGE,
        ST_SETTLE,
        ST_FLIGHT,
        ST_SWITCH,
        ST_OVER
    } state_t;

    localparam logic [2:0]  HP_RST      = 3'(HP_INIT);
    localparam logic [9:0]  FORCE_MIN   = 10'(MIN_FORCE);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] FLIGHT_LAST = 32'(FLIGHT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        turn_dog_q, turn_dog_d;
    logic [2:0]  hp_cat_q, hp_cat_d;
    logic [2:0]  hp_dog_q, hp_dog_d;
    logic [9:0]  force_out_q, force_out_d;
    logic        throw_start_q, throw_start_d;
    logic        space_cat_q, space_cat_d;
    logic        space_dog_q, space_dog_d;
    logic        game_over_q, game_over_d;
    logic        winner_dog_q, winner_dog_d;
    logic [31:0] cnt_q, cnt_d;
    logic        space_prev_q;
    logic [9:0]  active_force;

    assign active_force = turn_dog_q ? force_dog : force_cat;

    // State and registered-output flops, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ARM;
            turn_dog_q    <= 1'b0;
            hp_cat_q      <= HP_RST;
            hp_dog_q      <= HP_RST;
            force_out_q   <= '0;
            throw_start_q <= 1'b0;
            space_cat_q   <= 1'b0;
            space_dog_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_dog_q  <= 1'b0;
            cnt_q         <= '0;
            space_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            turn_dog_q    <= turn_dog_d;
            hp_cat_q      <= hp_cat_d;
            hp_dog_q      <= hp_dog_d;
            force_out_q   <= force_out_d;
            throw_start_q <= throw_start_d;
            space_cat_q   <= space_cat_d;
            space_dog_q   <= space_dog_d;
            game_over_q   <= game_over_d;
            winner_dog_q  <= winner_dog_d;
            cnt_q         <= cnt_d;
            space_prev_q  <= space_in;
        end
    end

    // Next-state and next-output logic; gates and launch pulse default low.
    always_comb begin
        state_d       = state_q;
        turn_dog_d    = turn_dog_q;
        hp_cat_d      = hp_cat_q;
        hp_dog_d      = hp_dog_q;
        force_out_d   = force_out_q;
        throw_start_d = 1'b0;
        space_cat_d   = 1'b0;
        space_dog_d   = 1'b0;
        game_over_d   = game_over_q;
        winner_dog_d  = winner_dog_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_ARM: begin
                cnt_d = '0;
                if (!space_in) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (space_in) begin
                    state_d     = ST_CHARGE;
                    space_cat_d = ~turn_dog_q;
                    space_dog_d = turn_dog_q;
                end
            end
            ST_CHARGE: begin
                if (!space_in) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    space_cat_d = ~turn_dog_q;
                    space_dog_d = turn_dog_q;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    // A foul leaves the previous launch force untouched so
                    // the engine never sees it change between launches.
                    if (active_force >= FORCE_MIN) begin
                        force_out_d   = active_force;
                        throw_start_d = 1'b1;
                        state_d       = ST_FLIGHT;
                    end else begin
                        state_d = ST_ARM;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_FLIGHT: begin
                // A real throw_done wins over a coinciding timeout.
                if (throw_done) begin
                    if (hit) begin
                        if (turn_dog_q) begin
                            if (hp_cat_q != 3'd0) hp_cat_d = hp_cat_q - 3'd1;
                        end else begin
                            if (hp_dog_q != 3'd0) hp_dog_d = hp_dog_q - 3'd1;
                        end
                    end
                    state_d = ST_SWITCH;
                end else if (cnt_q == FLIGHT_LAST) begin
                    state_d = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SWITCH: begin
                if (hp_cat_q == 3'd0 || hp_dog_q == 3'd0) begin
                    state_d      = ST_OVER;
                    game_over_d  = 1'b1;
                    winner_dog_d = (hp_cat_q == 3'd0);
                end else begin
                    turn_dog_d = ~turn_dog_q;
                    state_d    = ST_ARM;
                end
            end
            ST_OVER: begin
                if (space_in && !space_prev_q) begin
                    hp_cat_d     = HP_RST;
                    hp_dog_d     = HP_RST;
                    turn_dog_d   = 1'b0;
                    game_over_d  = 1'b0;
                    winner_dog_d = 1'b0;
                    state_d      = ST_ARM;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    assign space_cat       = space_cat_q;
    assign space_dog       = space_dog_q;
    assign turn_dog        = turn_dog_q;
    assign throw_start     = throw_start_q;
    assign throw_force_out = force_out_q;
    assign hp_cat          = hp_cat_q;
    assign hp_dog          = hp_dog_q;
    assign game_over       = game_over_q;
    assign winner_dog      = winner_dog_q;

endmodule
